// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control types: FSM states, register address width, stage-control word.
// Pure declarations; no latency or backpressure of its own.
package riscv_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    // Free-running pipeline: every register loads, no bubbles or flushes.
    localparam stage_ctrl_t CTRL_DEFAULT = stage_ctrl_t'(8'b1111_1000);
    // Everything frozen; used for halt.
    localparam stage_ctrl_t CTRL_FREEZE  = stage_ctrl_t'(8'b0000_0000);
    // Upstream frozen while MEM waits; WB drains and takes a bubble.
    localparam stage_ctrl_t CTRL_DWAIT   = stage_ctrl_t'(8'b0000_1001);

    function automatic logic load_use(
        input logic                  ex_mem_read,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  use_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  use_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return ex_mem_read && (ex_rd != '0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs from the pipeline and stage controls/status back from the stall controller.
// Wires only; master = pipeline datapath, slave = stall controller.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    import riscv_pipe_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mispredict;
    logic                  imem_ready;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  halt_req;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_write;
    logic                  ex_mem_write;
    logic                  mem_wb_write;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  mem_wb_bubble;
    logic                  halted;
    logic                  timeout;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_mispredict, imem_ready, dmem_req, dmem_ready, halt_req,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, mem_wb_bubble, halted, timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_mispredict, imem_ready, dmem_req, dmem_ready, halt_req,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, mem_wb_bubble, halted, timeout, stall_cycles
    );

endinterface

// File: rtl/dmem_wait_timer.sv
// Counts consecutive data-memory wait cycles and latches a sticky timeout at STALL_TIMEOUT.
// at_limit is combinational from the count; count and timeout update one edge later; no backpressure.
module dmem_wait_timer #(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic at_limit,
    output logic timeout
);

    logic [15:0] wait_cnt;

    assign at_limit = (wait_cnt == 16'(STALL_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else if (start) begin
            wait_cnt <= 16'd1;
        end else if (busy) begin
            if (at_limit) timeout <= 1'b1;
            else          wait_cnt <= wait_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Arbitrates halt, data-memory wait, mispredict, load-use and fetch stalls into per-stage enables.
// Stage controls are zero-latency Mealy outputs; halted/timeout/stall_cycles lag one edge; no backpressure.
module pipeline_stall_controller
    import riscv_pipe_pkg::*;
#(
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_stall_controller_if.slave  bus
);

    state_t           state, state_nxt;
    stage_ctrl_t      ctrl;
    logic             lu_hit;
    logic             timer_start;
    logic             timer_busy;
    logic             at_limit;
    logic             timeout;
    logic [CNT_W-1:0] stall_q;

    // Rules shared by RUN and the DWAIT release cycle.
    function automatic stage_ctrl_t resolve(
        input logic mispredict,
        input logic lu,
        input logic imem_ready
    );
        stage_ctrl_t c;
        c = CTRL_DEFAULT;
        if (mispredict) begin
            c.if_id_flush  = 1'b1;
            c.id_ex_bubble = 1'b1;
        end else if (lu) begin
            c.pc_write     = 1'b0;
            c.if_id_write  = 1'b0;
            c.id_ex_bubble = 1'b1;
        end else if (!imem_ready) begin
            c.pc_write     = 1'b0;
            c.if_id_flush  = 1'b1;
        end
        return c;
    endfunction

    assign lu_hit = load_use(bus.ex_mem_read, bus.ex_rd, bus.id_use_rs1, bus.id_rs1,
                             bus.id_use_rs2, bus.id_rs2);

    always_comb begin
        ctrl        = CTRL_DEFAULT;
        state_nxt   = state;
        timer_start = 1'b0;
        timer_busy  = 1'b0;
        case (state)
            RUN: begin
                if (bus.halt_req) begin
                    ctrl      = CTRL_FREEZE;
                    state_nxt = HALT;
                end else if (bus.dmem_req && !bus.dmem_ready) begin
                    ctrl        = CTRL_DWAIT;
                    state_nxt   = DWAIT;
                    timer_start = 1'b1;
                end else begin
                    ctrl = resolve(bus.ex_mispredict, lu_hit, bus.imem_ready);
                end
            end
            DWAIT: begin
                if (!bus.dmem_ready) begin
                    ctrl       = CTRL_DWAIT;
                    timer_busy = 1'b1;
                    if (at_limit) state_nxt = HALT;
                end else if (bus.halt_req) begin
                    ctrl      = CTRL_FREEZE;
                    state_nxt = HALT;
                end else begin
                    ctrl      = resolve(bus.ex_mispredict, lu_hit, bus.imem_ready);
                    state_nxt = RUN;
                end
            end
            HALT: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Saturating count of lost fetch cycles; halt time is not a stall.
    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (!ctrl.pc_write && (state != HALT) && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
    end

    dmem_wait_timer #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_dmem_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (timer_start),
        .busy     (timer_busy),
        .at_limit (at_limit),
        .timeout  (timeout)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.if_id_write   = ctrl.if_id_write;
    assign bus.id_ex_write   = ctrl.id_ex_write;
    assign bus.ex_mem_write  = ctrl.ex_mem_write;
    assign bus.mem_wb_write  = ctrl.mem_wb_write;
    assign bus.if_id_flush   = ctrl.if_id_flush;
    assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
    assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
    assign bus.halted        = (state == HALT);
    assign bus.timeout       = timeout;
    assign bus.stall_cycles  = stall_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It arbitrates four stall sources each cycle and drives the per-stage pipeline-register write enables and bubble/flush controls:
- data-memory wait,
- branch/jump mispredict,
- load-use hazard,
- instruction-fetch not ready.

It also tracks multi-cycle data-memory waits with a timeout, provides a sticky halt state, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- STALL_TIMEOUT, 255: maximum consecutive DWAIT cycles before timeout (range 1..65535).
- CNT_W, 32: width of stall_cycles.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads rs1/rs2.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_mispredict  in  1  EX resolved a redirect; PC mux selects the target.
- imem_ready  in  1  fetch data is valid this cycle.
- dmem_req  in  1  the MEM instruction accesses data memory.
- dmem_ready  in  1  the data-memory access completes this cycle.
- halt_req  in  1  the WB instruction is ecall/halt.
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register load enables.
- if_id_flush  out  1  IF/ID loads a NOP; asserted only together with if_id_write=1.
- id_ex_bubble  out  1  ID/EX loads zeroed control.
- mem_wb_bubble  out  1  MEM/WB loads zeroed control.
- halted  out  1  state==HALT.
- timeout  out  1  sticky; a DWAIT exceeded STALL_TIMEOUT.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0, excluding HALT.

## Operation
- FSM states: RUN, DWAIT, HALT. Reset puts the block in RUN with wait counter=0, timeout=0 and stall_cycles=0.
- Default outputs (RUN, idle inputs): all write enables=1; if_id_flush=0; id_ex_bubble=0; mem_wb_bubble=0.
- Load-use condition (LU): ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- RUN uses first-match priority:
  1. halt_req: all write enables=0; next state HALT.
  2. dmem_req && !dmem_ready: pc/if_id/id_ex/ex_mem write=0; mem_wb_write=1 with mem_wb_bubble=1; next state DWAIT; wait counter loads 1.
  3. ex_mispredict: pc_write=1; if_id_flush=1; id_ex_bubble=1. Overrides LU and !imem_ready.
  4. LU: pc_write=0; if_id_write=0; id_ex_bubble=1. Subsumes !imem_ready.
  5. !imem_ready: pc_write=0; if_id_flush=1; downstream stages advance.
- DWAIT:
  - While !dmem_ready: same outputs as RUN rule 2; counter increments.
  - When the counter equals STALL_TIMEOUT and dmem_ready=0: set timeout and go to HALT.
  - When dmem_ready=1 (release cycle): evaluate RUN rules 1, 3, 4 and 5 (rule 2 is skipped) and return to RUN, or go to HALT if rule 1 fires.
- HALT: all write enables=0 and all bubble/flush outputs=0. Only reset exits.
- stall_cycles increments when pc_write=0 and state!=HALT, and saturates at all-ones.

## Timing
- All stage controls are Mealy (combinational from state and inputs) and take effect at the same rising edge. Zero-cycle latency.
- halted, timeout and the counters are registered and change one edge after the cause.
- A load-use stall lasts exactly 1 cycle: the next cycle the load is in MEM, so LU is false.
- A mispredict costs 2 bubbles (IF/ID flush plus ID/EX bubble).
- Each DWAIT cycle inserts one MEM/WB bubble. The instruction that was in WB at DWAIT entry retires normally.
- Simultaneous halt_req and dmem miss: halt wins.
- Mispredict during DWAIT is held frozen in EX and applied on the release cycle.
- reset asserted mid-DWAIT or in HALT: RUN on the next edge, counters cleared, outputs back to defaults in that cycle.
- ex_rd=0 never causes LU.

## Structure
- Shared package riscv_pipe_pkg holds:
  - the state enum (RUN/DWAIT/HALT),
  - REG_ADDR_W=5,
  - the default-control constant used for bubbles.
- One sub-module, dmem_wait_timer, contains the DWAIT cycle counter, the compare against STALL_TIMEOUT and the sticky timeout flag. Everything else stays in the top module.

## Test plan
- Load-use: load x5 in EX, ID add reads rs1=x5 (use_rs1=1) -> for 1 cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle defaults; stall_cycles=1.
- No-use false hazard: ex_rd=0 with id_rs1=0, and separately id_rs2=x5 with use_rs2=0 -> no stall.
- Mispredict with LU and !imem_ready in the same cycle -> pc_write=1, if_id_flush=1, id_ex_bubble=1; stall_cycles unchanged.
- Data wait: dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles of freeze with mem_wb_bubble=1, release on the 4th cycle, back in RUN; stall_cycles=3.
- Timeout: STALL_TIMEOUT=4, dmem_ready held 0 -> after 4 DWAIT cycles timeout=1 and halted=1; outputs frozen; reset returns RUN with timeout=0.
- Halt plus reset: halt_req=1 while a miss is pending -> HALT, not DWAIT. Assert reset mid-HALT -> the next cycle shows defaults with all write enables=1.
